dilated_tap_cache: RTL and testbench
====================================

Name: dilated_tap_cache

Overview:
- Upstream feeder for the 8-input dot-product stage; holds the causal history of one activation channel in a ring buffer.
- On each accepted input sample it assembles the dilated 8-tap window x[t], x[t-D], ..., x[t-7D] and presents it as a_d0..a_d7 with a one-cycle valid pulse.
- Taps reaching before the first sample since reset read as zero (causal zero padding).

Parameters:
- W, 16, signed sample width in bits (fixed-point, same format as dot-product inputs).
- DILATION, 1, tap spacing D in samples; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- in_sample  input  W  signed new activation sample.
- in_v  input  1  in_sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- a_d0..a_d7  output  W each  signed window taps; a_dk = x[t - k*DILATION].
- out_v  output  1  one-cycle pulse: a_d0..a_d7 hold a new complete window.

Behaviour:
- Single clock; reset synchronous, active-high; rst has priority over every other event, including mid-window.
- Reset values: state IDLE, in_ready=1, out_v=0, a_d0..a_d7=0, write pointer wptr=0, fill count=0. RAM contents are not reset; the fill count gates them.
- Storage: ring of DEPTH = 7*DILATION+1 entries of W bits. Single write port, registered read port with 1-cycle latency.
- States:
  - IDLE: in_ready=1. If in_v, write in_sample at wptr, set count=min(count+1, DEPTH), go to READ with k=0.
  - READ: issue read address for tap k. The RAM registers the data; capture it into window register k-1 on the following cycle. After issuing k=7, go to CAPTURE.
  - CAPTURE: store tap 7, go to DONE.
  - DONE: out_v=1 for exactly this cycle, advance wptr (wrapping DEPTH-1 -> 0), go to IDLE.
- Read address for tap k: (wptr - k*D) mod DEPTH, computed as wptr-k*D if wptr >= k*D, else wptr+DEPTH-k*D. No modulo operator.
- Zero padding: tap k is forced to 0 when k*D >= count, using count after the write.
- Timing: accept at cycle 0, reads issued cycles 1-8, tap 7 captured cycle 9, out_v at cycle 10.
- in_ready is low from cycle 1 until and including the DONE cycle. Next accept is at the earliest cycle 11, giving throughput of 1 sample per 11 cycles. in_v while in_ready=0 is ignored; the sample is not stored.
- a_d0..a_d7 hold their values between out_v pulses. They are updated only at capture and never glitch to partial windows outside busy states.
- Count saturates at DEPTH. Past warm-up, all 8 taps come from RAM.
- Arithmetic: pointers and count are clog2(DEPTH+1) bits unsigned. No arithmetic is applied to sample data.

Optional Feature:
- Macro DILATED_TAP_CACHE_FLUSH_EN.
- With it defined: extra input port flush (1 bit).
  - In IDLE, flush=1 sets count=0; wptr is unchanged and no window is produced.
  - in_ready = IDLE && !flush, so flush beats a simultaneous in_v and that sample is not accepted.
  - flush is ignored in all other states.
- Without it: no flush port. History is cleared only by rst.

Decomposition:
- Shared package dcc_pkg:
  - localparam TAPS=8.
  - State enum typedef (IDLE, READ, CAPTURE, DONE).
  - Sample typedef parameterised on W, shared with dot_product.
- One natural sub-module: tap_ring_ram, a DEPTH x W ring with one write port and a registered read port.

Test Plan:
- Reset: hold rst 2 cycles -> in_ready=1, out_v=0, all a_dk=0. Release, no in_v for 20 cycles -> out_v stays 0.
- Warm-up, D=2: push 1, 2, 3 -> after the third sample out_v pulses 10 cycles after accept with a_d0=3, a_d1=1, a_d2..a_d7=0.
- Wrap, D=2 (DEPTH=15): push 1..20 -> final window a_d0..a_d7 = 20, 18, 16, 14, 12, 10, 8, 6.
- Backpressure: hold in_v=1 continuously with values 10, 11, 12 each for one cycle -> only 10 is stored. Next accept occurs exactly 11 cycles after the first.
- Reset mid-op: assert rst during READ -> no out_v. Next pushed sample 7 gives a_d0=7 and a_d1..a_d7=0.
- Flush (macro defined), D=1: push 1..8, flush, push 9 -> a_d0=9, others 0. flush+in_v in the same cycle -> sample not accepted.

Source files
------------

// File: rtl/dcc_pkg.sv
// Shared definitions for the dilated tap cache and the dot-product stage it feeds.
package dcc_pkg;

    localparam int TAPS     = 8;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        DONE
    } state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/tap_ring_ram.sv
// DEPTH x W ring storage: one write port, one read port with registered (1-cycle) data.
module tap_ring_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dilated_tap_cache.sv
// Dilated 8-tap window builder over a causal sample ring; optional history flush via DILATED_TAP_CACHE_FLUSH_EN.
// state   | meaning
// IDLE    | ready for a sample (or a flush)
// READ    | issue ring read for tap k, capture tap k-1 from the previous read
// CAPTURE | capture tap 7
// DONE    | out_v pulse, advance write pointer
module dilated_tap_cache
    import dcc_pkg::*;
#(
    parameter int W        = 16,
    parameter int DILATION = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_sample,
    input  logic                in_v,
`ifdef DILATED_TAP_CACHE_FLUSH_EN
    input  logic                flush,
`endif
    output logic                in_ready,
    output logic signed [W-1:0] a_d0,
    output logic signed [W-1:0] a_d1,
    output logic signed [W-1:0] a_d2,
    output logic signed [W-1:0] a_d3,
    output logic signed [W-1:0] a_d4,
    output logic signed [W-1:0] a_d5,
    output logic signed [W-1:0] a_d6,
    output logic signed [W-1:0] a_d7,
    output logic                out_v
);

    localparam int DEPTH = 7 * DILATION + 1;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int RAW   = $clog2(DEPTH);

    state_t              state;
    logic [2:0]          k;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       count;
    logic                ready_q;
    logic signed [W-1:0] win [TAPS];

    logic                flush_i;
    logic                accept;
    logic [2:0]          cap_k;
    logic                cap_zero;
    logic [PW-1:0]       rd_off;
    logic [RAW-1:0]      raddr;
    logic [W-1:0]        rdata;

`ifdef DILATED_TAP_CACHE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    function automatic logic [PW-1:0] tap_off(input logic [2:0] t);
        return PW'(int'(t) * DILATION);
    endfunction

    assign in_ready = ready_q & ~flush_i;
    assign accept   = (state == IDLE) && in_v && !flush_i;

    // Wrap without a modulo: wptr + DEPTH - off may overflow PW bits, but the true result is < DEPTH.
    assign rd_off = tap_off(k);
    assign raddr  = (wptr >= rd_off) ? RAW'(wptr - rd_off)
                                     : RAW'(wptr + PW'(DEPTH) - rd_off);

    assign cap_k    = (state == CAPTURE) ? 3'd7 : (k - 3'd1);
    assign cap_zero = (tap_off(cap_k) >= count);

    tap_ring_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (RAW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (RAW'(wptr)),
        .wdata (in_sample),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= 3'd0;
            wptr    <= '0;
            count   <= '0;
            ready_q <= 1'b1;
            out_v   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    out_v <= 1'b0;
                    if (flush_i) begin
                        count <= '0;
                    end else if (in_v) begin
                        count   <= (count == PW'(DEPTH)) ? count : count + 1'b1;
                        k       <= 3'd0;
                        ready_q <= 1'b0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (k != 3'd0) begin
                        win[cap_k] <= cap_zero ? '0 : rdata;
                    end
                    if (k == 3'd7) begin
                        state <= CAPTURE;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                CAPTURE: begin
                    win[cap_k] <= cap_zero ? '0 : rdata;
                    out_v      <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    out_v   <= 1'b0;
                    wptr    <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_d0 = win[0];
    assign a_d1 = win[1];
    assign a_d2 = win[2];
    assign a_d3 = win[3];
    assign a_d4 = win[4];
    assign a_d5 = win[5];
    assign a_d6 = win[6];
    assign a_d7 = win[7];

endmodule

// File: tb/tb_dilated_tap_cache.sv
// Bench for dilated_tap_cache (D=2): history-queue model checked every cycle plus directed literal checks.
module tb_dilated_tap_cache;

    localparam int W = 16;
    localparam int D = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic signed [W-1:0] in_sample = '0;
    logic                in_v = 1'b0;
    logic                flush = 1'b0;
    logic                in_ready;
    logic                out_v;
    logic signed [W-1:0] a_d0, a_d1, a_d2, a_d3, a_d4, a_d5, a_d6, a_d7;
    logic signed [W-1:0] taps [8];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hist[$];
    int pend [8];
    int held [8];
    int cd = 0;
    int got [8];
    int lat;

    dilated_tap_cache #(.W(W), .DILATION(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sample (in_sample),
        .in_v      (in_v),
`ifdef DILATED_TAP_CACHE_FLUSH_EN
        .flush     (flush),
`endif
        .in_ready  (in_ready),
        .a_d0      (a_d0),
        .a_d1      (a_d1),
        .a_d2      (a_d2),
        .a_d3      (a_d3),
        .a_d4      (a_d4),
        .a_d5      (a_d5),
        .a_d6      (a_d6),
        .a_d7      (a_d7),
        .out_v     (out_v)
    );

    assign taps[0] = a_d0;
    assign taps[1] = a_d1;
    assign taps[2] = a_d2;
    assign taps[3] = a_d3;
    assign taps[4] = a_d4;
    assign taps[5] = a_d5;
    assign taps[6] = a_d6;
    assign taps[7] = a_d7;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model: the window is read straight out of the full sample history since reset/flush.
    always @(negedge clk) begin
        if (rst) begin
            hist.delete();
            cd = 0;
            for (int k = 0; k < 8; k++) held[k] = 0;
        end else begin
            chk("in_ready", int'(in_ready), int'(cd == 0 && !flush));
            chk("out_v", int'(out_v), int'(cd == 1));
            if (cd == 1) begin
                for (int k = 0; k < 8; k++) held[k] = pend[k];
            end
            if (cd <= 1) begin
                for (int k = 0; k < 8; k++) chk($sformatf("a_d%0d", k), int'(taps[k]), held[k]);
            end
            if (cd > 0) begin
                cd--;
            end else if (flush) begin
                hist.delete();
            end else if (in_v) begin
                hist.push_back(int'(in_sample));
                for (int k = 0; k < 8; k++) begin
                    int idx;
                    idx = hist.size() - 1 - k * D;
                    pend[k] = (idx >= 0) ? hist[idx] : 0;
                end
                cd = 10;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_v = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push(input int v);
        int n;
        n = 0;
        in_sample = W'(v);
        in_v = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        acc_cyc = cyc;
        sync();
        in_v = 1'b0;
    endtask

    task automatic wait_out(output int l);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_v && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_v) chk("out_v_timeout", 0, 1);
        l = cyc - acc_cyc;
        for (int k = 0; k < 8; k++) got[k] = int'(taps[k]);
        sync();
    endtask

    task automatic count_outv(input int ncyc, output int npulse);
        npulse = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (out_v) npulse++;
        end
        sync();
    endtask

    initial begin
        int n, a, b;
        int exp_wrap [8];

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_v", int'(out_v), 0);
        for (int k = 0; k < 8; k++) chk($sformatf("rst_a_d%0d", k), int'(taps[k]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        count_outv(20, n);
        chk("idle_no_outv", n, 0);

        // Warm-up: 1, 2, 3
        push(1); wait_out(lat);
        push(2); wait_out(lat);
        push(3); wait_out(lat);
        chk("warm_latency", lat, 10);
        chk("warm_a_d0", got[0], 3);
        chk("warm_a_d1", got[1], 1);
        for (int k = 2; k < 8; k++) chk($sformatf("warm_a_d%0d", k), got[k], 0);

        // Wrap past DEPTH=15
        reset_dut();
        for (int v = 1; v <= 20; v++) begin
            push(v);
            wait_out(lat);
        end
        exp_wrap = '{20, 18, 16, 14, 12, 10, 8, 6};
        for (int k = 0; k < 8; k++) chk($sformatf("wrap_a_d%0d", k), got[k], exp_wrap[k]);

        // Backpressure: in_v held high, 11 and 12 land on a busy block
        reset_dut();
        in_v = 1'b1;
        in_sample = 16'sd10;
        @(negedge clk);
        chk("bp_first_ready", int'(in_ready), 1);
        a = cyc;
        sync(); in_sample = 16'sd11;
        sync(); in_sample = 16'sd12;
        sync(); in_sample = 16'sd13;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        b = cyc;
        acc_cyc = cyc;
        chk("bp_gap", b - a, 11);
        sync();
        in_v = 1'b0;
        wait_out(lat);
        chk("bp_latency", lat, 10);
        chk("bp_a_d0", got[0], 13);
        chk("bp_a_d1", got[1], 0);

        // Reset in the middle of READ
        push(5);
        repeat (2) sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        count_outv(15, n);
        chk("midrst_no_outv", n, 0);
        push(7);
        wait_out(lat);
        chk("midrst_a_d0", got[0], 7);
        for (int k = 1; k < 8; k++) chk($sformatf("midrst_a_d%0d", k), got[k], 0);

`ifdef DILATED_TAP_CACHE_FLUSH_EN
        reset_dut();
        for (int v = 1; v <= 8; v++) begin
            push(v);
            wait_out(lat);
        end
        flush = 1'b1;
        sync();
        flush = 1'b0;
        push(9);
        wait_out(lat);
        chk("flush_a_d0", got[0], 9);
        for (int k = 1; k < 8; k++) chk($sformatf("flush_a_d%0d", k), got[k], 0);
        flush = 1'b1;
        in_v = 1'b1;
        in_sample = 16'sd100;
        @(negedge clk);
        chk("flush_beats_in_v", int'(in_ready), 0);
        sync();
        flush = 1'b0;
        in_v = 1'b0;
        count_outv(12, n);
        chk("flush_no_outv", n, 0);
`endif

        repeat (3) sync();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
